// File: rtl/alien_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alien_rom_arbiter: round-robin, burst-bounded sharing of one sprite ROM     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alien_rom_arbiter #(
    parameter int NREQ  = 3,
    parameter int AW    = 10,
    parameter int DW    = 8,
    parameter int DEPTH = 837,
    parameter int BURST = 31
) (
    input  logic                 i_clk2,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*AW-1:0]   i_addr,
    output logic [NREQ-1:0]      o_gnt,
    output logic [AW-1:0]        o_rom_addr,
    input  logic [DW-1:0]        i_rom_data,
    output logic [DW-1:0]        o_data,
    output logic [NREQ-1:0]      o_valid,
    output logic                 o_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] C_BURST = CW'(BURST);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_s1_gnt;
    logic            r_s1_err;

    logic            w_others;
    logic            w_keep;
    logic            w_rr_found;
    logic [IW-1:0]   w_rr_idx;
    logic            w_any;
    logic [IW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_addr;
    logic            w_oor;

    always_comb begin
        w_others = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (k != int'(r_owner) && i_req[k]) w_others = 1'b1;
        end

        w_keep = (r_state == ST_OWN) && i_req[r_owner] &&
                 ((r_cnt < C_BURST) || !w_others);

        // Search starts just after the last grant and wraps back to it last.
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!w_rr_found && i_req[(int'(r_last) + off) % NREQ]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IW'((int'(r_last) + off) % NREQ);
            end
        end

        w_any     = (|i_req) && i_rst_n;
        w_gnt_idx = w_keep ? r_owner : w_rr_idx;

        w_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (k == int'(w_gnt_idx)) w_addr = i_addr[k*AW +: AW];
        end

        w_oor      = w_any && (int'(w_addr) >= DEPTH);
        o_gnt      = w_any ? (NREQ'(1) << w_gnt_idx) : '0;
        o_rom_addr = (w_any && !w_oor) ? w_addr : '0;
    end

    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_last   <= IW'(NREQ - 1);
            r_cnt    <= '0;
            r_s1_gnt <= '0;
            r_s1_err <= 1'b0;
            o_valid  <= '0;
            o_err    <= 1'b0;
            o_data   <= '0;
        end else begin
            if (!w_any) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= ST_OWN;
                r_owner <= w_gnt_idx;
                r_last  <= w_gnt_idx;
                // An expired burst kept only for lack of competition restarts at 1.
                if (w_keep) r_cnt <= (r_cnt < C_BURST) ? r_cnt + C_ONE : C_ONE;
                else        r_cnt <= C_ONE;
            end

            r_s1_gnt <= o_gnt;
            r_s1_err <= w_oor;
            o_valid  <= r_s1_gnt;
            o_err    <= r_s1_err;
            o_data   <= ((|r_s1_gnt) && !r_s1_err) ? i_rom_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alien_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alien_rom_arbiter: directed vector bench for alien_rom_arbiter          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alien_rom_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 837;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ-1:0]      gnt;
    logic [AW-1:0]        rom_addr;
    logic [DW-1:0]        rom_data;
    logic [DW-1:0]        data;
    logic [NREQ-1:0]      valid;
    logic                 err;

    always #5 clk = ~clk;

    alien_rom_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .BURST(31)
    ) dut (
        .i_clk2     (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_addr     (addr),
        .o_gnt      (gnt),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_data     (data),
        .o_valid    (valid),
        .o_err      (err)
    );

    function automatic logic [7:0] rom_f(input logic [9:0] a);
        logic [15:0] t;
        t = {6'd0, a} * 16'd7 + {9'd0, a[9:3]};
        return t[7:0] ^ 8'h5A;
    endfunction

    // Registered sprite ROM model
    always @(posedge clk) rom_data <= rom_f(rom_addr);

    typedef struct {
        logic [2:0] v;
        logic [7:0] d;
        logic       e;
    } ret_t;

    typedef struct {
        logic [2:0] req;
        logic [9:0] a0;
        logic [9:0] a1;
        logic [9:0] a2;
        logic [2:0] gnt;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    ret_t h0, h1;
    ret_t none_r;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at step %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] r,
                        input logic [9:0] a0, input logic [9:0] a1,
                        input logic [9:0] a2, input logic [2:0] eg);
        logic [9:0] ea;
        logic       ee;
        ret_t       nw;
        @(negedge clk);
        rst_n = rst;
        req   = r;
        addr  = {a2, a1, a0};
        #1;
        cyc++;
        if (!rst) begin
            h0 = none_r;
            h1 = none_r;
        end
        ea = eg[0] ? a0 : eg[1] ? a1 : eg[2] ? a2 : 10'd0;
        ee = (eg != 3'b000) && (ea >= 10'(DEPTH));
        chk("gnt",      32'(gnt),      32'(eg));
        chk("rom_addr", 32'(rom_addr), 32'(ee ? 10'd0 : ea));
        chk("valid",    32'(valid),    32'(h1.v));
        chk("err",      32'(err),      32'(h1.e));
        if (h1.v != 3'b000) chk("data", 32'(data), 32'(h1.d));
        nw.v = eg;
        nw.e = ee;
        nw.d = ee ? 8'd0 : rom_f(ea);
        h1 = h0;
        h0 = nw;
    endtask

    initial begin
        none_r.v = 3'b000;
        none_r.d = 8'd0;
        none_r.e = 1'b0;
        h0 = none_r;
        h1 = none_r;
        rst_n = 1'b0;
        req   = '0;
        addr  = '0;

        //           req     a0     a1     a2     gnt
        tbl[0]  = '{3'b000, 10'd0,  10'd0,  10'd0,   3'b000};
        tbl[1]  = '{3'b100, 10'd0,  10'd0,  10'd837, 3'b100};
        tbl[2]  = '{3'b100, 10'd0,  10'd0,  10'd836, 3'b100};
        tbl[3]  = '{3'b000, 10'd0,  10'd0,  10'd0,   3'b000};
        tbl[4]  = '{3'b000, 10'd0,  10'd0,  10'd0,   3'b000};
        tbl[5]  = '{3'b011, 10'd5,  10'd6,  10'd0,   3'b001};
        tbl[6]  = '{3'b010, 10'd0,  10'd7,  10'd0,   3'b010};
        tbl[7]  = '{3'b101, 10'd8,  10'd0,  10'd9,   3'b100};
        tbl[8]  = '{3'b011, 10'd10, 10'd11, 10'd0,   3'b001};
        tbl[9]  = '{3'b011, 10'd12, 10'd13, 10'd0,   3'b001};
        tbl[10] = '{3'b000, 10'd0,  10'd0,  10'd0,   3'b000};
        tbl[11] = '{3'b000, 10'd0,  10'd0,  10'd0,   3'b000};
        tbl[12] = '{3'b000, 10'd0,  10'd0,  10'd0,   3'b000};

        step(1'b0, 3'b011, 10'd1, 10'd2, 10'd3, 3'b000);
        step(1'b0, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000);

        for (int i = 0; i < 13; i++)
            step(1'b1, tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].gnt);

        // Two contenders: full bursts alternate with no idle cycle between them.
        step(1'b0, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000);
        for (int i = 0; i < 65; i++)
            step(1'b1, 3'b011, 10'(i), 10'(100 + i), 10'd0,
                 (i < 31) ? 3'b001 : (i < 62) ? 3'b010 : 3'b001);

        // Lone requester past the burst limit keeps the port.
        for (int i = 0; i < 40; i++)
            step(1'b1, 3'b010, 10'd0, 10'(200 + i), 10'd0, 3'b010);

        // Requester 0 streams one sprite row, then the pipe drains.
        for (int i = 0; i < 31; i++)
            step(1'b1, 3'b001, 10'(i), 10'd0, 10'd0, 3'b001);
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000);

        // Reset pulse mid-burst with accesses in flight.
        step(1'b0, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000);
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'b001, 10'(300 + i), 10'd0, 10'd0, 3'b001);
        step(1'b0, 3'b110, 10'd0, 10'd400, 10'd401, 3'b000);
        step(1'b1, 3'b110, 10'd0, 10'd400, 10'd401, 3'b010);
        step(1'b1, 3'b110, 10'd0, 10'd402, 10'd403, 3'b010);
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'b000, 10'd0, 10'd0, 10'd0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
